butterfly_cplx: RTL and testbench
=================================

# butterfly_cplx

Pipelined complex radix-2 butterfly for the 8-point FFT datapath. It computes X = (A + B) and Y = (A − B)·W, where the twiddle W is run-time selectable from the four 8-point factors. Each sample can optionally be scaled by ½. Streaming valid/ready handshakes on both sides let it replace the fixed real-only (in_1 ± in_2)/√2 stage and be chained between FFT stages with backpressure.

## Interface
- N, default 4: data width is 2**N bits (W). All data is signed two's complement.
- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous, active-low
- in_valid  in  1  input sample valid
- in_ready  out  1  block accepts a sample this cycle
- a_re, a_im, b_re, b_im  in  W each  complex operands A, B
- tw  in  2  twiddle select: 0→1, 1→(1−j)/√2, 2→−j, 3→−(1+j)/√2
- scale  in  1  1 = divide both outputs by 2
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts a sample
- x_re, x_im, y_re, y_im  out  W each  results X, Y

## Operation
- Constant: K = round(2^(W−1)/√2), unsigned W bits. K = 23170 for W = 16.
- Stage 1 (S1) registers the following, all W+1 bits:
  - s = A + B
  - d = A − B
  - tw and scale
- Stage 2 (S2) rotates d, with p = d_re + d_im and m = d_im − d_re (W+2 bits):
  - tw=0: r = d
  - tw=1: r = ((p·K)>>>(W−1), (m·K)>>>(W−1))
  - tw=2: r = (d_im, −d_re)
  - tw=3: r = ((m·K)>>>(W−1), (−p·K)>>>(W−1))
  - s passes through unchanged. >>> is arithmetic shift, so rounding is floor.
- Stage 3 (S3) output conditioning, per component v of s and r:
  - if scale = 1, v = v>>>1 (floor)
  - then reduce to W bits (see Configuration)
  - registers x_*, y_*
- Every tw value takes the same path length, so samples never reorder.
- Handshake:
  - en = !out_valid || out_ready
  - in_ready = en
  - all stages advance together only when en = 1
  - a transfer occurs when in_valid && in_ready
  - the valid bit shifts along with its data
- Bubbles are not collapsed. The pipeline holds up to 3 samples.
- While out_valid = 1 and out_ready = 0, the outputs and all stage registers hold stable.

## Timing
- Latency is 3 cycles: a sample accepted at edge t appears with out_valid = 1 after edge t+3, provided en stays 1.
- Throughput is 1 sample per cycle when out_ready = 1.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from in_valid to out_valid.
- Reset (rst = 0):
  - all valid bits, x_*, y_* and stage registers clear to 0 immediately
  - in_ready = 1 during and after reset
  - samples in flight are discarded
- Simultaneous events: an output handshake and an input handshake in the same cycle are both honoured.

## Configuration
- BFLY_SAT_EN defined: the S3 reduction to W bits saturates to [−2^(W−1), 2^(W−1)−1].
- BFLY_SAT_EN undefined: the S3 reduction keeps the low W bits (two's-complement wrap). No saturation logic is built.

## Test plan
All scenarios use W = 16.
- Basic, tw=0: A=(1000,0), B=(200,0), scale=0 → X=(1200,0), Y=(800,0), with out_valid exactly 3 cycles after acceptance.
- tw=1: same A, B → X=(1200,0), Y=(565,−566). tw=2 → Y=(0,−800). tw=3 → Y=(−566,−566).
- Overflow: A=(30000,0), B=(30000,0), tw=0.
  - scale=0 → X=(32767,0) with BFLY_SAT_EN, or (−5536,0) without.
  - scale=1 → X=(30000,0) in both builds.
- Backpressure: stream 6 samples with in_valid=1 and hold out_ready=0 from cycle 2 for 5 cycles.
  - in_ready falls once out_valid is high.
  - outputs hold stable.
  - all 6 results emerge in order, with no loss or duplication.
- Reset mid-stream: drive rst=0 while 3 samples are in flight.
  - out_valid=0 and outputs are 0 immediately.
  - after release, the next accepted sample emerges 3 cycles later with correct values.
- Random regression: 10k random A, B, tw, scale with random out_ready, checked against a bit-accurate reference model of the formulas above.

Source files
------------

// File: rtl/butterfly_cplx.sv
// Pipelined complex radix-2 butterfly: X = A + B, Y = (A - B) * W, optional halving, valid/ready stream.
// Optional build macro BFLY_SAT_EN: saturate the final W-bit reduction instead of wrapping.
module butterfly_cplx #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2**N-1:0]   a_re,
  input  logic [2**N-1:0]   a_im,
  input  logic [2**N-1:0]   b_re,
  input  logic [2**N-1:0]   b_im,
  input  logic [1:0]        tw,
  input  logic              scale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2**N-1:0]   x_re,
  output logic [2**N-1:0]   x_im,
  output logic [2**N-1:0]   y_re,
  output logic [2**N-1:0]   y_im
);

  localparam int W = 2**N;

  // K = round(2^(W-1)/sqrt2) = round(sqrt(2^(2W-3))), found by bitwise integer square root.
  function automatic logic [W-1:0] calc_k();
    logic [2*W+1:0] x;
    logic [2*W+1:0] r;
    logic [2*W+1:0] t;
    logic [2*W+1:0] u;
    logic [2*W+1:0] one;
    x = '0;
    x[2*W-3] = 1'b1;
    one = '0;
    one[0] = 1'b1;
    r = '0;
    for (int i = W - 1; i >= 0; i--) begin
      t = r;
      t[i] = 1'b1;
      if (t * t <= x) r = t;
    end
    u = r + r;
    u[0] = 1'b1;
    if ((x << 2) >= u * u) r = r + one;
    return r[W-1:0];
  endfunction

  localparam logic [W-1:0] K = calc_k();

  logic en;

  // Lane 0 is the real part, lane 1 the imaginary part.
  logic [W-1:0] a_c [2];
  logic [W-1:0] b_c [2];
  logic [W:0]   s_sum [2];
  logic [W:0]   d_dif [2];

  logic         s1_valid_reg;
  logic [1:0]   s1_tw_reg;
  logic         s1_scale_reg;
  logic [W:0]   s1_s_reg [2];
  logic [W:0]   s1_d_reg [2];

  logic         s2_valid_reg;
  logic         s2_scale_reg;
  logic [W:0]   s2_s_reg [2];
  logic [W+1:0] s2_r_reg [2];

  logic [W+1:0] lane_in  [4];
  logic [W-1:0] out_next [4];
  logic [W-1:0] out_reg  [4];
  logic         out_valid_reg;

  // A stall only exists while a finished sample waits for the consumer.
  assign en        = !out_valid_reg || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_reg;

  assign a_c[0] = a_re;
  assign a_c[1] = a_im;
  assign b_c[0] = b_re;
  assign b_c[1] = b_im;

  // ---------------- Stage 1: sum and difference ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_s1
    assign s_sum[gi] = {a_c[gi][W-1], a_c[gi]} + {b_c[gi][W-1], b_c[gi]};
    assign d_dif[gi] = {a_c[gi][W-1], a_c[gi]} - {b_c[gi][W-1], b_c[gi]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_reg <= 1'b0;
      s1_tw_reg    <= '0;
      s1_scale_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s1_s_reg[i] <= '0;
        s1_d_reg[i] <= '0;
      end
    end else if (en) begin
      s1_valid_reg <= in_valid;
      s1_tw_reg    <= tw;
      s1_scale_reg <= scale;
      for (int i = 0; i < 2; i++) begin
        s1_s_reg[i] <= s_sum[i];
        s1_d_reg[i] <= d_dif[i];
      end
    end
  end

  // ---------------- Stage 2: twiddle rotation of d ----------------
  logic [W+1:0]   d_re_x;
  logic [W+1:0]   d_im_x;
  logic [W+1:0]   p_sum;
  logic [W+1:0]   m_dif;
  logic [2*W+2:0] prod_p;
  logic [2*W+2:0] prod_m;
  logic [2*W+2:0] prod_n;
  logic [W+1:0]   pk;
  logic [W+1:0]   mk;
  logic [W+1:0]   nk;
  logic [W+1:0]   rot_re;
  logic [W+1:0]   rot_im;
  logic           unused_prod;

  assign d_re_x = {s1_d_reg[0][W], s1_d_reg[0]};
  assign d_im_x = {s1_d_reg[1][W], s1_d_reg[1]};
  assign p_sum  = d_re_x + d_im_x;
  assign m_dif  = d_im_x - d_re_x;

  // Operands are sign/zero-extended to the full product width, so the unsigned
  // multiply yields the exact two's-complement signed product.
  assign prod_p = {{(W+1){p_sum[W+1]}}, p_sum} * {{(W+3){1'b0}}, K};
  assign prod_m = {{(W+1){m_dif[W+1]}}, m_dif} * {{(W+3){1'b0}}, K};
  assign prod_n = '0 - prod_p;

  // Selecting bits [2W:W-1] is the arithmetic shift right by W-1 (floor).
  assign pk = prod_p[2*W:W-1];
  assign mk = prod_m[2*W:W-1];
  assign nk = prod_n[2*W:W-1];
  assign unused_prod = ^{prod_p[2*W+2:2*W+1], prod_p[W-2:0],
                         prod_m[2*W+2:2*W+1], prod_m[W-2:0],
                         prod_n[2*W+2:2*W+1], prod_n[W-2:0]};

  always_comb begin
    rot_re = d_re_x;
    rot_im = d_im_x;
    case (s1_tw_reg)
      2'd1: begin
        rot_re = pk;
        rot_im = mk;
      end
      2'd2: begin
        rot_re = d_im_x;
        rot_im = '0 - d_re_x;
      end
      2'd3: begin
        rot_re = mk;
        rot_im = nk;
      end
      default: begin
        rot_re = d_re_x;
        rot_im = d_im_x;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_reg <= 1'b0;
      s2_scale_reg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        s2_s_reg[i] <= '0;
        s2_r_reg[i] <= '0;
      end
    end else if (en) begin
      s2_valid_reg <= s1_valid_reg;
      s2_scale_reg <= s1_scale_reg;
      s2_s_reg[0]  <= s1_s_reg[0];
      s2_s_reg[1]  <= s1_s_reg[1];
      s2_r_reg[0]  <= rot_re;
      s2_r_reg[1]  <= rot_im;
    end
  end

  // ---------------- Stage 3: scaling and reduction to W bits ----------------
  // Lanes 0/1 carry X (re/im), lanes 2/3 carry Y (re/im).
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign lane_in[gi]     = {s2_s_reg[gi][W], s2_s_reg[gi]};
    assign lane_in[gi + 2] = s2_r_reg[gi];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_s3
    logic [W+1:0] v;
    assign v = s2_scale_reg ? {lane_in[gi][W+1], lane_in[gi][W+1:1]} : lane_in[gi];
`ifdef BFLY_SAT_EN
    logic ovf;
    // Fits in W bits only when the top three bits are all copies of the sign.
    assign ovf          = (v[W+1:W-1] != {3{v[W+1]}});
    assign out_next[gi] = ovf ? {v[W+1], {(W-1){~v[W+1]}}} : v[W-1:0];
`else
    logic unused_hi;
    assign unused_hi    = ^v[W+1:W];
    assign out_next[gi] = v[W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        out_reg[i] <= '0;
      end
    end else if (en) begin
      out_valid_reg <= s2_valid_reg;
      for (int i = 0; i < 4; i++) begin
        out_reg[i] <= out_next[i];
      end
    end
  end

  assign x_re = out_reg[0];
  assign x_im = out_reg[1];
  assign y_re = out_reg[2];
  assign y_im = out_reg[3];

endmodule

// File: tb/tb_butterfly_cplx.sv
// Self-checking bench for butterfly_cplx (W = 16): directed cases, backpressure, reset, random stream vs model.
module tb_butterfly_cplx;

  localparam longint KC = 23170;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_re, a_im, b_re, b_im;
  logic [1:0]  tw;
  logic        scale;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x_re, x_im, y_re, y_im;
  logic [63:0] outs;

  int n_checks = 0;
  int n_pass   = 0;
  logic [63:0] exp_q[$];

  butterfly_cplx #(.N(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .tw(tw), .scale(scale),
    .out_valid(out_valid), .out_ready(out_ready),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im)
  );

  assign outs = {x_re, x_im, y_re, y_im};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  // Output conditioning: optional floor halving, then wrap or clamp to 16 bits.
  function automatic logic [15:0] cond(input longint v, input bit sc);
    longint t;
    t = sc ? (v >>> 1) : v;
`ifdef BFLY_SAT_EN
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
`endif
    return 16'(t);
  endfunction

  function automatic logic [63:0] model(input logic [15:0] ar, ai, br, bi,
                                        input logic [1:0] t, input bit sc);
    longint sr, si, dr, di, p, m, yr, yi;
    sr = longint'($signed(ar)) + longint'($signed(br));
    si = longint'($signed(ai)) + longint'($signed(bi));
    dr = longint'($signed(ar)) - longint'($signed(br));
    di = longint'($signed(ai)) - longint'($signed(bi));
    p  = dr + di;
    m  = di - dr;
    case (t)
      2'd0:    begin yr = dr;             yi = di;                end
      2'd1:    begin yr = (p * KC) >>> 15; yi = (m * KC) >>> 15;   end
      2'd2:    begin yr = di;             yi = -dr;               end
      default: begin yr = (m * KC) >>> 15; yi = (-p * KC) >>> 15;  end
    endcase
    return {cond(sr, sc), cond(si, sc), cond(yr, sc), cond(yi, sc)};
  endfunction

  // One isolated sample: checks the 3-cycle latency and the result values.
  task automatic run_one(input string tag, input int ar, ai, br, bi, input int t, input bit sc,
                         input int xr, xi, yr, yi);
    @(negedge clk);
    a_re = 16'(ar); a_im = 16'(ai); b_re = 16'(br); b_im = 16'(bi);
    tw = 2'(t); scale = sc; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 1) in_valid = 1'b0;
      chk({tag, "_latency"}, 64'(out_valid), (k == 3) ? 64'd1 : 64'd0);
    end
    chk({tag, "_data"}, outs, {16'(xr), 16'(xi), 16'(yr), 16'(yi)});
    $display("txn %s: x=(%0d,%0d) y=(%0d,%0d)", tag, $signed(x_re), $signed(x_im),
             $signed(y_re), $signed(y_im));
  endtask

  // Streamed samples against the model; rnd=0 runs the fixed backpressure script.
  task automatic stream(input string tag, input int nsamp, input bit rnd);
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit prev_stall = 1'b0;
    logic [63:0] prev_out = '0;
    exp_q.delete();
    while (got < nsamp && cyc < nsamp * 10 + 50) begin
      @(negedge clk);
      if (prev_stall) begin
        chk({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_hold_data"}, outs, prev_out);
      end
      in_valid = (sent < nsamp) ? (rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
      a_re = 16'($urandom); a_im = 16'($urandom);
      b_re = 16'($urandom); b_im = 16'($urandom);
      tw = 2'($urandom_range(0, 3)); scale = 1'($urandom_range(0, 1));
      out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 2 && cyc < 7);
      #1;
      if (!rnd) begin
        chk({tag, "_in_ready"}, 64'(in_ready), 64'(!out_valid || out_ready));
        if (cyc == 3) chk({tag, "_in_ready_low"}, 64'(in_ready), 64'd0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(a_re, a_im, b_re, b_im, tw, scale));
        sent++;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk({tag, "_unexpected"}, 64'd1, 64'd0);
        else chk({tag, "_data"}, outs, exp_q.pop_front());
        $display("txn %s %0d: x=(%0d,%0d) y=(%0d,%0d)", tag, got, $signed(x_re), $signed(x_im),
                 $signed(y_re), $signed(y_im));
        got++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = outs;
      cyc++;
    end
    chk({tag, "_count"}, 64'(got), 64'(nsamp));
    // No duplicates may follow the last expected result.
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk({tag, "_drain"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw = '0; scale = 1'b0;
    #1 rst = 1'b0;
    #2;
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_data", outs, 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    run_one("tw0", 1000, 0, 200, 0, 0, 1'b0, 1200, 0, 800, 0);
    run_one("tw1", 1000, 0, 200, 0, 1, 1'b0, 1200, 0, 565, -566);
    run_one("tw2", 1000, 0, 200, 0, 2, 1'b0, 1200, 0, 0, -800);
    run_one("tw3", 1000, 0, 200, 0, 3, 1'b0, 1200, 0, -566, -566);
`ifdef BFLY_SAT_EN
    run_one("ovf_noscale", 30000, 0, 30000, 0, 0, 1'b0, 32767, 0, 0, 0);
`else
    run_one("ovf_noscale", 30000, 0, 30000, 0, 0, 1'b0, -5536, 0, 0, 0);
`endif
    run_one("ovf_scale", 30000, 0, 30000, 0, 0, 1'b1, 30000, 0, 0, 0);

    stream("bp", 6, 1'b0);

    // Reset with three samples in flight.
    @(negedge clk);
    a_re = 16'd1000; a_im = '0; b_re = 16'd200; b_im = '0; tw = '0; scale = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_data", outs, 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run_one("post_rst", 1000, 0, 200, 0, 1, 1'b0, 1200, 0, 565, -566);

    stream("rand", 10000, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
